// File: rtl/calc_sequencer.sv
// calc_sequencer
//   Operation sequencer for the calculator. It debounces the single progress
//   button and acts on each release. The releases step through three stages:
//   operand A entry, operand B entry and operator entry. Each release latches
//   the switches for the current stage. After the operator is latched, the
//   sequencer starts the ALU and waits for it to finish or time out. It then
//   holds the result for display until the next release.
//
// Ports
//   clk          system clock; all logic runs on the rising edge
//   reset        asynchronous, active-low reset
//   progress     raw push-button (1 = pressed), asynchronous to clk
//   clear        synchronous abort back to ENTER_A; operands are kept
//   sw           operand switches
//   op_sel       operator switches: 00 add, 01 sub, 10 mul, 11 div
//   alu_done     ALU completion pulse
//   alu_error    ALU error flag, valid with alu_done
//   alu_result   ALU result, valid with alu_done
//   op_a, op_b   latched operands
//   op_code      latched operator
//   alu_start    one-cycle ALU start pulse
//   en_a/b/op    one-hot entry-stage indicators
//   busy         high while in EXEC
//   result       held result
//   result_valid high in SHOW after a good result
//   error        high in SHOW after an ALU error or a timeout
//   state_dbg    current FSM state
//
// ALU handshake
//   alu_start is a single-cycle request. The sequencer does not issue a
//   second request while one is outstanding. The ALU answers with one
//   alu_done pulse, and alu_result and alu_error are valid in that same
//   cycle. The sequencer accepts alu_done only in EXEC, and only from the
//   cycle after alu_start.
module calc_sequencer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               progress,
    input  logic               clear,
    input  logic [WIDTH-1:0]   sw,
    input  logic [1:0]         op_sel,
    input  logic               alu_done,
    input  logic               alu_error,
    input  logic [2*WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    output logic [1:0]         op_code,
    output logic               alu_start,
    output logic               en_a,
    output logic               en_b,
    output logic               en_op,
    output logic               busy,
    output logic [2*WIDTH-1:0] result,
    output logic               result_valid,
    output logic               error,
    output logic [2:0]         state_dbg
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_ENTER_A  = 3'd0,
        S_ENTER_B  = 3'd1,
        S_ENTER_OP = 3'd2,
        S_EXEC     = 3'd3,
        S_SHOW     = 3'd4
    } state_t;

    state_t            state, state_next;
    logic [1:0]        sync_q;
    logic              db_level, db_level_d;
    logic [DB_W-1:0]   db_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              rel;
    logic              first_exec;
    logic              load_a, load_b, load_op;
    logic              take_done, take_tmo, ack_show;

    assign state_dbg = state;

    // Button path: two-flop synchroniser, then the debouncer. The
    // debouncer accepts a new level only after the synchronised input has
    // disagreed with the current level for DEBOUNCE_CYCLES cycles in a
    // row. Any agreement in between restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= 2'b00;
            db_level   <= 1'b0;
            db_level_d <= 1'b0;
            db_cnt     <= '0;
        end else begin
            sync_q     <= {sync_q[0], progress};
            db_level_d <= db_level;
            if (sync_q[1] == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level <= sync_q[1];
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Only the release (debounced 1 -> 0) advances the sequence.
    assign rel = db_level_d & ~db_level;

    // tmo_cnt is 0 in the first EXEC cycle, so this also marks the cycle
    // that carries alu_start.
    assign first_exec = (tmo_cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_ENTER_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        alu_start  = 1'b0;
        en_a       = 1'b0;
        en_b       = 1'b0;
        en_op      = 1'b0;
        busy       = 1'b0;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        take_done  = 1'b0;
        take_tmo   = 1'b0;
        ack_show   = 1'b0;
        case (state)
            S_ENTER_A: begin
                en_a = 1'b1;
                if (rel) begin
                    load_a     = 1'b1;
                    state_next = S_ENTER_B;
                end
            end
            S_ENTER_B: begin
                en_b = 1'b1;
                if (rel) begin
                    load_b     = 1'b1;
                    state_next = S_ENTER_OP;
                end
            end
            S_ENTER_OP: begin
                en_op = 1'b1;
                if (rel) begin
                    load_op    = 1'b1;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                busy      = 1'b1;
                alu_start = first_exec;
                // If alu_done and the last timeout cycle coincide,
                // alu_done wins.
                if (!first_exec && alu_done) begin
                    take_done  = 1'b1;
                    state_next = S_SHOW;
                end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    take_tmo   = 1'b1;
                    state_next = S_SHOW;
                end
            end
            S_SHOW: begin
                if (rel) begin
                    ack_show   = 1'b1;
                    state_next = S_ENTER_A;
                end
            end
            default: state_next = S_ENTER_A;
        endcase
        // clear overrides a release or an alu_done in the same cycle.
        if (clear) begin
            state_next = S_ENTER_A;
            alu_start  = 1'b0;
            load_a     = 1'b0;
            load_b     = 1'b0;
            load_op    = 1'b0;
            take_done  = 1'b0;
            take_tmo   = 1'b0;
            ack_show   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a         <= '0;
            op_b         <= '0;
            op_code      <= 2'b00;
            result       <= '0;
            result_valid <= 1'b0;
            error        <= 1'b0;
            tmo_cnt      <= '0;
        end else begin
            if (load_a)  op_a    <= sw;
            if (load_b)  op_b    <= sw;
            if (load_op) op_code <= op_sel;

            if (clear || ack_show) begin
                result_valid <= 1'b0;
                error        <= 1'b0;
            end else if (take_done) begin
                result       <= alu_result;
                error        <= alu_error;
                result_valid <= ~alu_error;
            end else if (take_tmo) begin
                result       <= '0;
                error        <= 1'b1;
                result_valid <= 1'b0;
            end

            // The counter runs only while the sequencer stays in EXEC. It
            // reads zero in the first EXEC cycle of every run.
            if (state == S_EXEC && state_next == S_EXEC) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer
//   Directed bench for calc_sequencer with WIDTH=8, DEBOUNCE_CYCLES=4 and
//   TIMEOUT_CYCLES=16. Expected results go into exp_q when the bench drives
//   the ALU answer or forces a timeout. They are popped when the sequencer
//   reaches SHOW.
module tb_calc_sequencer;

  localparam int W   = 8;
  localparam int DEB = 4;
  localparam int TMO = 16;

  localparam logic [2:0] S_A  = 3'd0;
  localparam logic [2:0] S_B  = 3'd1;
  localparam logic [2:0] S_OP = 3'd2;
  localparam logic [2:0] S_EX = 3'd3;
  localparam logic [2:0] S_SH = 3'd4;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic           progress = 1'b0;
  logic           clear = 1'b0;
  logic [W-1:0]   sw = '0;
  logic [1:0]     op_sel = 2'b00;
  logic           alu_done = 1'b0;
  logic           alu_error = 1'b0;
  logic [2*W-1:0] alu_result = '0;
  logic [W-1:0]   op_a, op_b;
  logic [1:0]     op_code;
  logic           alu_start, en_a, en_b, en_op, busy, result_valid, error;
  logic [2*W-1:0] result;
  logic [2:0]     state_dbg;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  logic [2*W-1:0] exp_q[$];

  calc_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .progress(progress), .clear(clear),
    .sw(sw), .op_sel(op_sel), .alu_done(alu_done), .alu_error(alu_error),
    .alu_result(alu_result), .op_a(op_a), .op_b(op_b), .op_code(op_code),
    .alu_start(alu_start), .en_a(en_a), .en_b(en_b), .en_op(en_op),
    .busy(busy), .result(result), .result_valid(result_valid),
    .error(error), .state_dbg(state_dbg)
  );

  always @(negedge clk) if (alu_start === 1'b1) start_cnt++;

  // checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: press and release the button, then wait (bounded) for the
  // state to move. Returns on the first negedge in the new state.
  task automatic press(input string tag);
    logic [2:0] s0;
    logic moved;
    s0 = state_dbg;
    moved = 1'b0;
    progress = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    progress = 1'b0;
    for (int i = 0; i < DEB + 10; i++) begin
      @(negedge clk);
      if (state_dbg !== s0) begin
        moved = 1'b1;
        break;
      end
    end
    check({tag, "_advanced"}, moved, 1);
  endtask

  task automatic enter_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op, input string tag);
    sw = a;      press({tag, "_a"});
    sw = b;      press({tag, "_b"});
    op_sel = op; press({tag, "_op"});
    check({tag, "_exec"}, state_dbg, S_EX);
  endtask

  // scoreboard: wait for SHOW (bounded), count busy cycles, pop expected result
  task automatic wait_show(input string tag, output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < TMO + 20; i++) begin
      if (state_dbg !== S_EX) break;
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
    end
    check({tag, "_show"}, state_dbg, S_SH);
    check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) check({tag, "_result"}, result, exp_q.pop_front());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int base;

    // reset state
    @(negedge clk);
    check("rst_state", state_dbg, S_A);
    check("rst_en", {en_a, en_b, en_op}, 3'b100);
    check("rst_ops", {op_a, op_b, op_code}, 0);
    check("rst_result", result, 0);
    check("rst_flags", {alu_start, busy, result_valid, error}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: full operation 12 + 5
    sw = 8'd12; press("t1_a");
    check("t1_en_b", {en_a, en_b, en_op}, 3'b010);
    check("t1_op_a", op_a, 12);
    sw = 8'd5; press("t1_b");
    check("t1_en_op", {en_a, en_b, en_op}, 3'b001);
    check("t1_op_b", op_b, 5);
    base = start_cnt;
    op_sel = 2'b00; press("t1_op");
    check("t1_busy", busy, 1);
    check("t1_start", alu_start, 1);
    @(negedge clk);
    check("t1_start_once", alu_start, 0);
    repeat (2) @(negedge clk);
    alu_done = 1'b1; alu_result = 16'd17; exp_q.push_back(16'd17);
    @(negedge clk);
    alu_done = 1'b0; alu_result = '0;
    wait_show("t1", bc);
    check("t1_valid_err", {result_valid, error}, 2'b10);
    check("t1_en_off", {en_a, en_b, en_op, busy}, 0);
    check("t1_ops", {op_a, op_b, op_code}, {8'd12, 8'd5, 2'd0});
    check("t1_start_cnt", start_cnt - base, 1);
    repeat (3) @(negedge clk);
    check("t1_held", result, 17);
    press("t1_ack");
    check("t1_back_a", {en_a, result_valid}, 2'b10);
    check("t1_op_a_kept", op_a, 12);

    // 2: bouncing button never accepted; a clean press advances once
    for (int i = 0; i < 10; i++) begin
      progress = ~progress;
      repeat (2) @(negedge clk);
    end
    progress = 1'b0;
    repeat (DEB + 8) @(negedge clk);
    check("t2_bounce_ignored", state_dbg, S_A);
    sw = 8'd33; press("t2_clean");
    check("t2_one_step", state_dbg, S_B);
    repeat (DEB + 8) @(negedge clk);
    check("t2_still_b", state_dbg, S_B);
    check("t2_op_a", op_a, 33);

    // 4: ALU error (div by zero)
    sw = 8'd0; press("t4_b");
    op_sel = 2'b11; press("t4_op");
    check("t4_exec", state_dbg, S_EX);
    repeat (2) @(negedge clk);
    alu_done = 1'b1; alu_error = 1'b1; alu_result = 16'hDEAD;
    exp_q.push_back(16'hDEAD);
    @(negedge clk);
    alu_done = 1'b0; alu_error = 1'b0; alu_result = '0;
    wait_show("t4", bc);
    check("t4_valid_err", {result_valid, error}, 2'b01);
    check("t4_ops", {op_a, op_b, op_code}, {8'd33, 8'd0, 2'd3});
    press("t4_ack");
    check("t4_err_clr", {en_a, error}, 2'b10);

    // 3: timeout after exactly TMO cycles in EXEC
    enter_op(8'd1, 8'd2, 2'b10, "t3");
    exp_q.push_back('0);
    wait_show("t3", bc);
    check("t3_busy_cycles", bc, TMO);
    check("t3_valid_err", {result_valid, error}, 2'b01);
    press("t3_ack");

    // alu_done outside EXEC is ignored
    alu_done = 1'b1; alu_result = 16'h1234;
    @(negedge clk);
    alu_done = 1'b0; alu_result = '0;
    @(negedge clk);
    check("idle_done_state", state_dbg, S_A);
    check("idle_done_result", result, 0);

    // 5: clear in the same cycle as alu_done
    enter_op(8'd7, 8'd4, 2'b01, "t5");
    repeat (2) @(negedge clk);
    alu_done = 1'b1; alu_result = 16'h0055; clear = 1'b1;
    @(negedge clk);
    alu_done = 1'b0; alu_result = '0; clear = 1'b0;
    check("t5_state", state_dbg, S_A);
    check("t5_flags", {en_a, busy, result_valid, error, alu_start}, 5'b10000);
    check("t5_result", result, 0);
    check("t5_ops_kept", {op_a, op_b, op_code}, {8'd7, 8'd4, 2'd1});

    // 6: reset mid-EXEC, late alu_done ignored
    enter_op(8'd9, 8'd3, 2'b00, "t6");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_async_state", state_dbg, S_A);
    check("t6_async_busy", {busy, alu_start}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    alu_done = 1'b1; alu_result = 16'h0099;
    @(negedge clk);
    alu_done = 1'b0; alu_result = '0;
    @(negedge clk);
    check("t6_state", state_dbg, S_A);
    check("t6_en", {en_a, en_b, en_op}, 3'b100);
    check("t6_ops", {op_a, op_b, op_code}, 0);
    check("t6_result", result, 0);
    check("t6_flags", {alu_start, busy, result_valid, error}, 0);

    // final report
    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
